// File: rtl/display_sequencer.sv
// Result display sequencer: snapshots N_GRP x N_ELEM result elements on entry to display
// and presents them one at a time, auto-advancing every HOLD cycles or on step edges.
module display_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_GRP  = 3,
  parameter int unsigned N_ELEM = 4,
  parameter int unsigned HOLD   = 2,
  parameter int unsigned LOOP   = 1,
  localparam int unsigned GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1,
  localparam int unsigned EW    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run_display,
  input  logic                            mode,
  input  logic                            step,
  input  logic [N_GRP*N_ELEM*DATA_W-1:0]  data_i,
  output logic [DATA_W-1:0]               display_result_o,
  output logic [GW-1:0]                   grp_o,
  output logic [EW-1:0]                   elem_o,
  output logic [1:0]                      state_display_o,
  output logic                            valid_o,
  output logic                            done_o
);

  localparam int unsigned DW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW-1:0] LastDwell = DW'(HOLD - 1);
  localparam logic [GW-1:0] LastGrp   = GW'(N_GRP - 1);
  localparam logic [EW-1:0] LastElem  = EW'(N_ELEM - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StShow = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e                           r_state;
  logic [N_GRP*N_ELEM*DATA_W-1:0]   r_snap;
  logic [DW-1:0]                    r_dwell;
  logic [GW-1:0]                    r_grp;
  logic [EW-1:0]                    r_elem;
  logic                             r_step_prev;
  logic                             r_done;

  logic w_rise;
  logic w_adv;

  assign w_rise = step & ~r_step_prev;
  assign w_adv  = mode ? w_rise : (r_dwell == LastDwell);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_snap      <= '0;
      r_dwell     <= '0;
      r_grp       <= '0;
      r_elem      <= '0;
      r_step_prev <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_step_prev <= step;
      r_done      <= 1'b0;
      case (r_state)
        StIdle: begin
          if (run_display) r_state <= StLoad;
        end
        StLoad: begin
          if (!run_display) begin
            r_state <= StIdle;
          end else begin
            r_snap  <= data_i;
            r_state <= StShow;
            r_grp   <= '0;
            r_elem  <= '0;
            r_dwell <= '0;
          end
        end
        StShow: begin
          if (!run_display) begin
            // Leaving display wins over any advance due on this edge
            r_state <= StIdle;
            r_grp   <= '0;
            r_elem  <= '0;
            r_dwell <= '0;
          end else begin
            if (mode || w_adv) r_dwell <= '0;
            else               r_dwell <= r_dwell + 1'b1;
            if (w_adv) begin
              if (r_elem != LastElem) begin
                r_elem <= r_elem + 1'b1;
              end else if (r_grp != LastGrp) begin
                r_elem <= '0;
                r_grp  <= r_grp + 1'b1;
              end else if (LOOP != 0) begin
                r_elem <= '0;
                r_grp  <= '0;
              end else begin
                // Indices stay on the last element so DONE keeps showing it
                r_state <= StDone;
                r_done  <= 1'b1;
              end
            end
          end
        end
        StDone: begin
          if (!run_display) begin
            r_state <= StIdle;
            r_grp   <= '0;
            r_elem  <= '0;
            r_dwell <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    display_result_o = '0;
    if (r_state == StShow || r_state == StDone) begin
      display_result_o = r_snap[(int'(r_grp) * N_ELEM + int'(r_elem)) * DATA_W +: DATA_W];
    end
  end

  assign grp_o           = r_grp;
  assign elem_o          = r_elem;
  assign state_display_o = r_state;
  assign valid_o         = (r_state == StShow);
  assign done_o          = r_done;

endmodule

// File: tb/tb_display_sequencer.sv
// Bench for display_sequencer: two instances (looping HOLD=2, one-shot HOLD=1) share stimulus
// and are checked every cycle against a position-based model, plus literal expectations.
module tb_display_sequencer;

  localparam int NE = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_display = 1'b0;
  logic        mode = 1'b0;
  logic        step = 1'b0;
  logic [95:0] data = '0;

  logic [7:0] d0_out, d1_out;
  logic [1:0] d0_grp, d1_grp, d0_elem, d1_elem, d0_state, d1_state;
  logic       d0_valid, d1_valid, d0_done, d1_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: linear position 0..11 instead of group/element indices
  int         m_state[2];
  int         m_pos[2];
  int         m_cnt[2];
  int         m_done[2];
  logic [7:0] m_snap[2][NE];
  logic       m_prev;
  int         m_hold[2] = '{2, 1};
  int         m_loop[2] = '{1, 0};

  display_sequencer u_dut0 (
    .clk(clk), .reset(reset), .run_display(run_display), .mode(mode), .step(step),
    .data_i(data), .display_result_o(d0_out), .grp_o(d0_grp), .elem_o(d0_elem),
    .state_display_o(d0_state), .valid_o(d0_valid), .done_o(d0_done)
  );

  display_sequencer #(.HOLD(1), .LOOP(0)) u_dut1 (
    .clk(clk), .reset(reset), .run_display(run_display), .mode(mode), .step(step),
    .data_i(data), .display_result_o(d1_out), .grp_o(d1_grp), .elem_o(d1_elem),
    .state_display_o(d1_state), .valid_o(d1_valid), .done_o(d1_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0;
      m_pos[k]   = 0;
      m_cnt[k]   = 0;
      m_done[k]  = 0;
      for (int p = 0; p < NE; p++) m_snap[k][p] = 8'h00;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_edge();
    logic rise;
    logic adv;
    rise = step && !m_prev;
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      case (m_state[k])
        0: if (run_display) m_state[k] = 1;
        1: begin
          if (!run_display) m_state[k] = 0;
          else begin
            for (int p = 0; p < NE; p++) m_snap[k][p] = data[p*8 +: 8];
            m_state[k] = 2;
            m_pos[k]   = 0;
            m_cnt[k]   = 0;
          end
        end
        2: begin
          if (!run_display) begin
            m_state[k] = 0;
            m_pos[k]   = 0;
            m_cnt[k]   = 0;
          end else begin
            adv = mode ? rise : (m_cnt[k] == m_hold[k] - 1);
            m_cnt[k] = (mode || adv) ? 0 : m_cnt[k] + 1;
            if (adv) begin
              if (m_pos[k] < NE - 1) m_pos[k]++;
              else if (m_loop[k] != 0) m_pos[k] = 0;
              else begin
                m_state[k] = 3;
                m_done[k]  = 1;
              end
            end
          end
        end
        default: begin
          if (!run_display) begin
            m_state[k] = 0;
            m_pos[k]   = 0;
            m_cnt[k]   = 0;
          end
        end
      endcase
    end
    m_prev = step;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_edge();
    end
  end

  task automatic compare_one(input int k, input int out, input int grp, input int elem,
                             input int st, input int valid, input int done);
    int shown;
    shown = (m_state[k] >= 2);
    check($sformatf("cyc%0d_out", k), out, shown ? int'(m_snap[k][m_pos[k]]) : 0);
    check($sformatf("cyc%0d_grp", k), grp, shown ? m_pos[k] / 4 : 0);
    check($sformatf("cyc%0d_elem", k), elem, shown ? m_pos[k] % 4 : 0);
    check($sformatf("cyc%0d_state", k), st, m_state[k]);
    check($sformatf("cyc%0d_valid", k), valid, int'(m_state[k] == 2));
    check($sformatf("cyc%0d_done", k), done, m_done[k]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        compare_one(0, int'(d0_out), int'(d0_grp), int'(d0_elem), int'(d0_state),
                    int'(d0_valid), int'(d0_done));
        compare_one(1, int'(d1_out), int'(d1_grp), int'(d1_elem), int'(d1_state),
                    int'(d1_valid), int'(d1_done));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_counting();
    for (int p = 0; p < NE; p++) data[p*8 +: 8] = 8'(p + 1);
  endtask

  initial begin
    #1 reset = 1'b0;
    chk_en = 1'b1;
    load_counting();
    repeat (3) @(negedge clk);
    check("rst_state", int'(d0_state), 0);
    check("rst_out", int'(d0_out), 0);
    reset = 1'b1;
    tick();
    check("idle_hold", int'(d0_state), 0);

    // Auto mode: LOAD for one cycle, then 1,1,2,2,... and a one-shot run on dut1
    run_display = 1'b1;
    tick();
    check("load_state0", int'(d0_state), 1);
    check("load_state1", int'(d1_state), 1);
    tick();
    data = {96{1'b1}};
    for (int i = 0; i < 24; i++) begin
      check("auto_seq0", int'(d0_out), i / 2 + 1);
      check("auto_valid0", int'(d0_valid), 1);
      if (i < 12) check("oneshot_seq1", int'(d1_out), i + 1);
      if (i == 12) begin
        check("oneshot_done", int'(d1_done), 1);
        check("oneshot_state", int'(d1_state), 3);
        check("oneshot_hold", int'(d1_out), 12);
      end
      if (i == 13) begin
        check("oneshot_done_pulse", int'(d1_done), 0);
        check("oneshot_hold2", int'(d1_out), 12);
      end
      tick();
    end
    check("wrap_out0", int'(d0_out), 1);
    check("wrap_grp0", int'(d0_grp), 0);
    run_display = 1'b0;
    tick();
    check("drop_state0", int'(d0_state), 0);
    check("drop_out1", int'(d1_out), 0);

    // Step mode
    load_counting();
    mode = 1'b1;
    run_display = 1'b1;
    tick();
    tick();
    check("step_first", int'(d0_out), 1);
    step = 1'b1;
    repeat (3) tick();
    check("step_held", int'(d0_out), 2);
    step = 1'b0; tick();
    step = 1'b1; tick();
    check("step_pulse2", int'(d0_out), 3);
    step = 1'b0; tick();
    step = 1'b1; tick();
    check("step_pulse3", int'(d0_out), 4);
    step = 1'b0;
    repeat (3) tick();
    check("step_none", int'(d0_out), 4);
    repeat (3) begin
      step = 1'b1; tick();
      step = 1'b0; tick();
    end
    check("step_el7", int'(d0_out), 7);
    check("step_el7_grp", int'(d0_grp), 1);
    check("step_el7_elem", int'(d0_elem), 2);
    run_display = 1'b0;
    tick();
    check("abort_state", int'(d0_state), 0);
    check("abort_out", int'(d0_out), 0);
    mode = 1'b0;
    run_display = 1'b1;
    tick();
    tick();
    check("restart_out", int'(d0_out), 1);

    // Asynchronous reset between edges
    repeat (3) tick();
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_state0", int'(d0_state), 0);
    check("async_out0", int'(d0_out), 0);
    check("async_valid1", int'(d1_valid), 0);
    @(negedge clk);
    run_display = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_idle", int'(d0_state), 0);
    run_display = 1'b1;
    tick();
    check("post_rst_load", int'(d0_state), 1);

    // Randomized phase, checked by the per-cycle compare process
    for (int c = 0; c < 3000; c++) begin
      if (run_display) run_display = ($urandom_range(0, 99) != 0);
      else run_display = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 2) == 0) step = ~step;
      if ($urandom_range(0, 7) == 0) data = {$urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
